llc_snoop_responder: RTL and testbench

LLC-side responder for snooped bus operations issued by other processors, the opposite end of the LLC's own bus-op/snoop-result exchange. The block accepts one snooped operation at a time and looks up the line in the tag/MESI store. It then drives the snoop result (HIT/HITM/NOHIT), sequences the required L2-to-L1 messages and modified-line write-back, and commits the new MESI state. It sits between the bus-snoop port and the LLC tag/MESI array, beside the L1 message channel.

---
 rtl/llc_snoop_responder_pkg.sv | 37 +++
 rtl/snoop_action_decode.sv | 77 +++++++
 rtl/llc_snoop_responder.sv | 167 ++++++++++++++++
 tb/tb_llc_snoop_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/llc_snoop_responder_pkg.sv
// Shared cache definitions for the LLC snoop responder: FSM states, bus/snoop/L1/MESI
// encodings and the address-field split.
package llc_snoop_responder_pkg;

  localparam int ADDR_WIDTH_DEF  = 32;
  localparam int OFFSET_BITS_DEF = 6;
  localparam int INDEX_BITS_DEF  = 14;
  localparam int WAY_BITS_DEF    = 4;
  localparam int TAG_BITS_DEF    = ADDR_WIDTH_DEF - INDEX_BITS_DEF - OFFSET_BITS_DEF;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_RESP   = 3'd2;
  localparam logic [2:0] ST_GETL   = 3'd3;
  localparam logic [2:0] ST_WBACK  = 3'd4;
  localparam logic [2:0] ST_INVL   = 3'd5;
  localparam logic [2:0] ST_UPDATE = 3'd6;

  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_WRITE = 3'd2;
  localparam logic [2:0] OP_INVAL = 3'd3;
  localparam logic [2:0] OP_RWIM  = 3'd4;

  localparam logic [1:0] RES_HIT   = 2'b00;
  localparam logic [1:0] RES_HITM  = 2'b01;
  localparam logic [1:0] RES_NOHIT = 2'b11;

  localparam logic [2:0] L1_NONE    = 3'd0;
  localparam logic [2:0] L1_GETLINE = 3'd1;
  localparam logic [2:0] L1_INVLINE = 3'd3;

  localparam logic [1:0] MESI_I = 2'b00;
  localparam logic [1:0] MESI_E = 2'b01;
  localparam logic [1:0] MESI_M = 2'b10;
  localparam logic [1:0] MESI_S = 2'b11;

endpackage

// File: rtl/snoop_action_decode.sv
// Pure decode of a snooped op against the looked-up line state into the bus result,
// the follow-up actions and the committed MESI state.
module snoop_action_decode
  import llc_snoop_responder_pkg::*;
(
  input  logic [2:0] op,
  input  logic       hit,
  input  logic [1:0] mesi,
  output logic [1:0] result,
  output logic       need_getl,
  output logic       need_wb,
  output logic       need_inv,
  output logic [1:0] new_mesi,
  output logic       do_upd,
  output logic       err
);

  // action table
  always_comb begin
    result    = RES_NOHIT;
    need_getl = 1'b0;
    need_wb   = 1'b0;
    need_inv  = 1'b0;
    new_mesi  = MESI_I;
    do_upd    = 1'b0;
    err       = 1'b0;
    case (op)
      OP_READ: begin
        if (hit && mesi == MESI_M) begin
          result    = RES_HITM;
          need_getl = 1'b1;
          need_wb   = 1'b1;
          new_mesi  = MESI_S;
          do_upd    = 1'b1;
        end else if (hit && mesi == MESI_E) begin
          result   = RES_HIT;
          new_mesi = MESI_S;
          do_upd   = 1'b1;
        end else if (hit) begin
          result = RES_HIT;
        end else begin
          result = RES_NOHIT;
        end
      end
      OP_RWIM: begin
        if (hit && mesi == MESI_M) begin
          result    = RES_HITM;
          need_getl = 1'b1;
          need_wb   = 1'b1;
          need_inv  = 1'b1;
          do_upd    = 1'b1;
        end else if (hit) begin
          result   = RES_HIT;
          need_inv = 1'b1;
          do_upd   = 1'b1;
        end else begin
          result = RES_NOHIT;
        end
      end
      OP_INVAL: begin
        // another owner invalidating a line we hold exclusively is incoherent
        if (hit && mesi == MESI_S) begin
          result   = RES_HIT;
          need_inv = 1'b1;
          do_upd   = 1'b1;
        end else if (hit) begin
          err = 1'b1;
        end else begin
          result = RES_NOHIT;
        end
      end
      OP_WRITE: result = RES_NOHIT;
      default:  err = 1'b1;
    endcase
  end

endmodule

// File: rtl/llc_snoop_responder.sv
// LLC snoop responder: accepts one snooped bus op, looks up the line, drives the snoop
// result and sequences L1 messages, write-back and the MESI commit.
module llc_snoop_responder
  import llc_snoop_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int OFFSET_BITS = OFFSET_BITS_DEF,
  parameter int INDEX_BITS  = INDEX_BITS_DEF,
  parameter int WAY_BITS    = WAY_BITS_DEF,
  parameter int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  snp_valid,
  output logic                  snp_ready,
  input  logic [2:0]            snp_op,
  input  logic [ADDR_WIDTH-1:0] snp_addr,
  output logic                  snoop_valid,
  output logic [1:0]            snoop_result,
  output logic                  lk_req,
  output logic [INDEX_BITS-1:0] lk_index,
  output logic [TAG_BITS-1:0]   lk_tag,
  input  logic                  lk_hit,
  input  logic [WAY_BITS-1:0]   lk_way,
  input  logic [1:0]            lk_mesi,
  output logic                  upd_valid,
  output logic [INDEX_BITS-1:0] upd_index,
  output logic [WAY_BITS-1:0]   upd_way,
  output logic [1:0]            upd_mesi,
  output logic                  l1_valid,
  input  logic                  l1_ready,
  output logic [2:0]            l1_msg,
  output logic [ADDR_WIDTH-1:0] l1_addr,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [ADDR_WIDTH-1:0] wb_addr,
  output logic                  protocol_err
);

  localparam int LINE_BITS = ADDR_WIDTH - OFFSET_BITS;

  logic [2:0]           r_state, w_next;
  logic [LINE_BITS-1:0] r_line;
  logic [2:0]           r_op;
  logic [WAY_BITS-1:0]  r_way;
  logic [1:0]           r_new_mesi;
  logic                 r_p_getl, r_p_wb, r_p_inv, r_p_upd;
  logic                 w_p_getl, w_p_wb, w_p_inv, w_p_upd;
  logic [2:0]           w_follow;
  logic                 w_hit, w_accept;
  logic [1:0]           w_result, w_new_mesi;
  logic                 w_getl, w_wb, w_inv, w_upd, w_err;
  logic                 r_snp_ready, r_lk_req, r_l1_valid, r_wb_valid, r_upd_valid;
  logic [2:0]           r_l1_msg;

  assign w_hit    = lk_hit && (lk_mesi != MESI_I);
  assign w_accept = r_snp_ready && snp_valid;

  snoop_action_decode u_decode (
    .op        (r_op),
    .hit       (w_hit),
    .mesi      (lk_mesi),
    .result    (w_result),
    .need_getl (w_getl),
    .need_wb   (w_wb),
    .need_inv  (w_inv),
    .new_mesi  (w_new_mesi),
    .do_upd    (w_upd),
    .err       (w_err)
  );

  // pending actions: loaded at RESP, each retired by its own phase
  always_comb begin
    w_p_getl = 1'b0;
    w_p_wb   = 1'b0;
    w_p_inv  = 1'b0;
    w_p_upd  = 1'b0;
    case (r_state)
      ST_RESP:  {w_p_getl, w_p_wb, w_p_inv, w_p_upd} = {w_getl, w_wb, w_inv, w_upd};
      ST_GETL:  {w_p_getl, w_p_wb, w_p_inv, w_p_upd} = {1'b0, r_p_wb, r_p_inv, r_p_upd};
      ST_WBACK: {w_p_getl, w_p_wb, w_p_inv, w_p_upd} = {1'b0, 1'b0, r_p_inv, r_p_upd};
      ST_INVL:  {w_p_getl, w_p_wb, w_p_inv, w_p_upd} = {1'b0, 1'b0, 1'b0, r_p_upd};
      default:  {w_p_getl, w_p_wb, w_p_inv, w_p_upd} = 4'b0000;
    endcase
    if (w_p_getl)     w_follow = ST_GETL;
    else if (w_p_wb)  w_follow = ST_WBACK;
    else if (w_p_inv) w_follow = ST_INVL;
    else if (w_p_upd) w_follow = ST_UPDATE;
    else              w_follow = ST_IDLE;
  end

  // next state
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   w_next = w_accept ? ST_LOOKUP : ST_IDLE;
      ST_LOOKUP: w_next = ST_RESP;
      ST_RESP:   w_next = w_follow;
      ST_GETL:   w_next = (r_l1_valid && l1_ready) ? w_follow : ST_GETL;
      ST_WBACK:  w_next = (r_wb_valid && wb_ready) ? w_follow : ST_WBACK;
      ST_INVL:   w_next = (r_l1_valid && l1_ready) ? w_follow : ST_INVL;
      default:   w_next = ST_IDLE;
    endcase
  end

  // state, captured op context and outputs registered from the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_line      <= '0;
      r_op        <= 3'd0;
      r_way       <= '0;
      r_new_mesi  <= MESI_I;
      {r_p_getl, r_p_wb, r_p_inv, r_p_upd} <= 4'b0000;
      r_snp_ready <= 1'b0;
      r_lk_req    <= 1'b0;
      r_l1_valid  <= 1'b0;
      r_l1_msg    <= L1_NONE;
      r_wb_valid  <= 1'b0;
      r_upd_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_line <= snp_addr[ADDR_WIDTH-1:OFFSET_BITS];
        r_op   <= snp_op;
      end else begin
        r_line <= r_line;
        r_op   <= r_op;
      end
      if (r_state == ST_RESP) begin
        r_way      <= lk_way;
        r_new_mesi <= w_new_mesi;
      end else begin
        r_way      <= r_way;
        r_new_mesi <= r_new_mesi;
      end
      {r_p_getl, r_p_wb, r_p_inv, r_p_upd} <= {w_p_getl, w_p_wb, w_p_inv, w_p_upd};
      r_snp_ready <= (w_next == ST_IDLE);
      r_lk_req    <= (w_next == ST_LOOKUP);
      r_l1_valid  <= (w_next == ST_GETL) || (w_next == ST_INVL);
      r_l1_msg    <= (w_next == ST_GETL) ? L1_GETLINE :
                     (w_next == ST_INVL) ? L1_INVLINE : L1_NONE;
      r_wb_valid  <= (w_next == ST_WBACK);
      r_upd_valid <= (w_next == ST_UPDATE);
    end
  end

  // the snoop result must appear in the lookup-response cycle, so it decodes live
  assign snoop_valid  = (r_state == ST_RESP);
  assign snoop_result = snoop_valid ? w_result : RES_NOHIT;
  assign protocol_err = snoop_valid && w_err;

  assign snp_ready = r_snp_ready;
  assign lk_req    = r_lk_req;
  assign lk_index  = r_line[INDEX_BITS-1:0];
  assign lk_tag    = r_line[LINE_BITS-1:INDEX_BITS];
  assign upd_valid = r_upd_valid;
  assign upd_index = r_line[INDEX_BITS-1:0];
  assign upd_way   = r_way;
  assign upd_mesi  = r_new_mesi;
  assign l1_valid  = r_l1_valid;
  assign l1_msg    = r_l1_msg;
  assign l1_addr   = {r_line, {OFFSET_BITS{1'b0}}};
  assign wb_valid  = r_wb_valid;
  assign wb_addr   = {r_line, {OFFSET_BITS{1'b0}}};

endmodule

// File: tb/tb_llc_snoop_responder.sv
// Directed self-checking bench for llc_snoop_responder; lookup inputs are held static per op.
module tb_llc_snoop_responder;

  logic        clk = 1'b0;
  logic        rst_n, snp_valid, snp_ready;
  logic [2:0]  snp_op;
  logic [31:0] snp_addr;
  logic        snoop_valid;
  logic [1:0]  snoop_result;
  logic        lk_req;
  logic [13:0] lk_index;
  logic [11:0] lk_tag;
  logic        lk_hit;
  logic [3:0]  lk_way;
  logic [1:0]  lk_mesi;
  logic        upd_valid;
  logic [13:0] upd_index;
  logic [3:0]  upd_way;
  logic [1:0]  upd_mesi;
  logic        l1_valid, l1_ready;
  logic [2:0]  l1_msg;
  logic [31:0] l1_addr;
  logic        wb_valid, wb_ready;
  logic [31:0] wb_addr;
  logic        protocol_err;

  int n_chk  = 0;
  int n_pass = 0;
  int sv_cyc[$];

  llc_snoop_responder dut (
    .clk(clk), .rst_n(rst_n), .snp_valid(snp_valid), .snp_ready(snp_ready),
    .snp_op(snp_op), .snp_addr(snp_addr), .snoop_valid(snoop_valid),
    .snoop_result(snoop_result), .lk_req(lk_req), .lk_index(lk_index), .lk_tag(lk_tag),
    .lk_hit(lk_hit), .lk_way(lk_way), .lk_mesi(lk_mesi), .upd_valid(upd_valid),
    .upd_index(upd_index), .upd_way(upd_way), .upd_mesi(upd_mesi),
    .l1_valid(l1_valid), .l1_ready(l1_ready), .l1_msg(l1_msg), .l1_addr(l1_addr),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // presents one op for a single accept edge; returns in cycle E0+1
  task automatic start_op(input logic [2:0] op, input logic [31:0] a,
                          input logic h, input logic [1:0] m);
    snp_op = op; snp_addr = a; lk_hit = h; lk_mesi = m; snp_valid = 1'b1;
    tick();
    snp_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; snp_valid = 1'b0; snp_op = 3'd0; snp_addr = 32'd0;
    lk_hit = 1'b0; lk_way = 4'hA; lk_mesi = 2'b00; l1_ready = 1'b1; wb_ready = 1'b1;
    tick(); tick();
    chk("rst_ready", snp_ready, 0);
    chk("rst_result", snoop_result, 2'b11);
    chk("rst_outs", {snoop_valid, lk_req, upd_valid, l1_valid, wb_valid, protocol_err}, 0);
    chk("rst_l1msg", l1_msg, 0);
    chk("rst_addr", {l1_addr, wb_addr}, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_ready", snp_ready, 1);

    // READ hitting M: HITM, GETLINE, write-back, downgrade to S
    start_op(3'd1, 32'h0001_2340, 1'b1, 2'b10);
    chk("m_lkreq", lk_req, 1);
    chk("m_lkidx", lk_index, 14'h048D);
    chk("m_lktag", lk_tag, 12'h000);
    chk("m_busy", snp_ready, 0);
    tick();
    chk("m_sv", {snoop_valid, snoop_result}, {1'b1, 2'b01});
    tick();
    chk("m_getl", {l1_valid, l1_msg}, {1'b1, 3'd1});
    chk("m_l1addr", l1_addr, 32'h0001_2340);
    tick();
    chk("m_wb", {wb_valid, l1_valid}, 2'b10);
    chk("m_wbaddr", wb_addr, 32'h0001_2340);
    tick();
    chk("m_upd", {upd_valid, upd_mesi, upd_way}, {1'b1, 2'b11, 4'hA});
    chk("m_updidx", upd_index, 14'h048D);
    tick();
    chk("m_done", {snp_ready, upd_valid}, 2'b10);

    // RWIM hitting S with a slow L1: INVALIDATELINE held, then invalidate
    l1_ready = 1'b0;
    start_op(3'd4, 32'hABCD_E7C5, 1'b1, 2'b11);
    chk("rw_lktag", lk_tag, 12'hABC);
    tick();
    chk("rw_sv", {snoop_valid, snoop_result}, {1'b1, 2'b00});
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rw_hold", {l1_valid, l1_msg, l1_addr}, {1'b1, 3'd3, 32'hABCD_E7C0});
    end
    l1_ready = 1'b1;
    tick();
    chk("rw_upd", {upd_valid, upd_mesi, l1_valid}, {1'b1, 2'b00, 1'b0});
    chk("rw_updidx", upd_index, 14'h379F);
    tick();
    chk("rw_done", snp_ready, 1);

    // READ miss, then READ hit in S: no MESI change, idle at E0+3
    start_op(3'd1, 32'h0000_1000, 1'b0, 2'b10);
    tick();
    chk("miss_sv", {snoop_valid, snoop_result, protocol_err}, {1'b1, 2'b11, 1'b0});
    tick();
    chk("miss_done", {snp_ready, upd_valid, l1_valid}, 3'b100);
    start_op(3'd1, 32'h0000_2000, 1'b1, 2'b11);
    tick();
    chk("s_sv", {snoop_valid, snoop_result}, {1'b1, 2'b00});
    tick();
    chk("s_done", {snp_ready, upd_valid, l1_valid}, 3'b100);

    // illegal combinations
    start_op(3'd3, 32'h0000_3000, 1'b1, 2'b10);
    tick();
    chk("invm_sv", {snoop_valid, snoop_result, protocol_err}, {1'b1, 2'b11, 1'b1});
    tick();
    chk("invm_done", {snp_ready, upd_valid, protocol_err}, 3'b100);
    start_op(3'd6, 32'h0000_4000, 1'b1, 2'b11);
    tick();
    chk("op6_sv", {snoop_valid, snoop_result, protocol_err}, {1'b1, 2'b11, 1'b1});
    tick();
    chk("op6_done", {snp_ready, upd_valid, protocol_err}, 3'b100);

    // reset while in write-back
    wb_ready = 1'b0;
    start_op(3'd1, 32'h0005_0040, 1'b1, 2'b10);
    tick(); tick(); tick();
    chk("rw_inwb", wb_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst", {snp_ready, snoop_valid, lk_req, upd_valid, l1_valid, wb_valid,
                    protocol_err}, 0);
    chk("mid_rst_res", {snoop_result, l1_msg, wb_addr}, {2'b11, 3'd0, 32'd0});
    wb_ready = 1'b1;
    tick();
    chk("mid_rst_noupd", upd_valid, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", snp_ready, 1);
    start_op(3'd1, 32'h0006_0080, 1'b1, 2'b01);
    tick();
    chk("post_sv", {snoop_valid, snoop_result}, {1'b1, 2'b00});
    tick();
    chk("post_upd", {upd_valid, upd_mesi}, {1'b1, 2'b11});
    tick();
    chk("post_done", snp_ready, 1);

    // snp_valid held high: second op waits for snp_ready
    snp_op = 3'd1; snp_addr = 32'h0000_5000; lk_hit = 1'b0; snp_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 2) chk("b2b_busy", snp_ready, 0);
      if (snoop_valid) sv_cyc.push_back(c);
    end
    snp_valid = 1'b0;
    chk("b2b_count", sv_cyc.size(), 2);
    if (sv_cyc.size() == 2) chk("b2b_gap", sv_cyc[1] - sv_cyc[0], 3);
    tick(); tick();
    chk("b2b_idle", snp_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
